coeff_batch_ctrl: RTL

- Upstream controller for the coefficient accumulator datapath.
- Accepts a valid/ready stream of coefficients and writes them into the accumulator's coefficient SRAM (addresses 0..NumCoeffs-1) through its external write port.
- Then pulses start, tracks busy/done with a watchdog, and captures the final accumulator value.
- Returns that value on a valid/ready result interface. One batch in flight at a time.

---
 rtl/coeff_batch_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/coeff_batch_ctrl.sv
// coeff_batch_ctrl: upstream controller for the coefficient accumulator.
// Streams NumCoeffs coefficients into the accumulator's coefficient SRAM,
// pulses start, watches busy/done under a watchdog, captures the result and
// hands it out on a valid/ready interface. One batch in flight at a time.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), synchronous active-low reset
//   coeff_valid_i/ready_o/data_i  coefficient input stream
//   mem_a_we_o/addr_o/wdata_o     coefficient SRAM write port (same-cycle as handshake)
//   start_o                       one-cycle start pulse to the accumulator
//   busy_i, done_i, accumulator_i accumulator status and value
//   result_valid_o/ready_i, result_o  result output stream
//   error_o                       sticky watchdog error
//   clear_i                       clears the error and returns to loading
module coeff_batch_ctrl #(
  parameter int unsigned NumCoeffs     = 16,
  parameter int unsigned CoeffWidth    = 8,
  parameter int unsigned AddrWidth     = 4,
  parameter int unsigned ResultWidth   = 16,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   coeff_valid_i,
  output logic                   coeff_ready_o,
  input  logic [CoeffWidth-1:0]  coeff_data_i,
  output logic                   mem_a_we_o,
  output logic [AddrWidth-1:0]   mem_a_addr_o,
  output logic [CoeffWidth-1:0]  mem_a_wdata_o,
  output logic                   start_o,
  input  logic                   busy_i,
  input  logic                   done_i,
  input  logic [ResultWidth-1:0] accumulator_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [ResultWidth-1:0] result_o,
  output logic                   error_o,
  input  logic                   clear_i
);

  localparam int unsigned TimerWidth = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone,
    StResult,
    StError
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   wr_cnt_q, wr_cnt_d;
  logic [TimerWidth-1:0]  timer_q, timer_d, timer_inc;
  logic [ResultWidth-1:0] result_q, result_d;
  logic                   coeff_ready_q, start_q, result_valid_q, error_q;
  logic                   coeff_hs;

  // Coefficient handshake; ready is only ever high in LOAD.
  assign coeff_hs = coeff_ready_q & coeff_valid_i;

  // Saturating watchdog increment.
  assign timer_inc = (timer_q == TimerWidth'(TimeoutCycles)) ? timer_q
                                                              : timer_q + TimerWidth'(1);

  // Write port is driven straight from the handshake so the beat lands with zero latency.
  assign mem_a_we_o    = coeff_hs;
  assign mem_a_addr_o  = wr_cnt_q;
  assign mem_a_wdata_o = coeff_hs ? coeff_data_i : '0;

  assign coeff_ready_o  = coeff_ready_q;
  assign start_o        = start_q;
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign error_o        = error_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    timer_d  = timer_q;
    result_d = result_q;
    unique case (state_q)
      StLoad: begin
        if (coeff_hs) begin
          if (wr_cnt_q == AddrWidth'(NumCoeffs - 1)) begin
            wr_cnt_d = '0;
            state_d  = StStart;
          end else begin
            wr_cnt_d = wr_cnt_q + AddrWidth'(1);
          end
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        // A done that coincides with the busy rise completes the batch directly.
        if (busy_i && done_i) begin
          result_d = accumulator_i;
          state_d  = StResult;
        end else if (busy_i) begin
          timer_d = '0;
          state_d = StWaitDone;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TimerWidth'(TimeoutCycles)) begin
            state_d = StError;
          end
        end
      end
      StWaitDone: begin
        if (done_i) begin
          result_d = accumulator_i;
          state_d  = StResult;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TimerWidth'(TimeoutCycles)) begin
            state_d = StError;
          end
        end
      end
      StResult: begin
        if (result_ready_i) begin
          state_d = StLoad;
        end
      end
      StError: begin
        if (clear_i) begin
          wr_cnt_d = '0;
          timer_d  = '0;
          state_d  = StLoad;
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // State, datapath and registered output flops (outputs decoded from next state).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StLoad;
      wr_cnt_q       <= '0;
      timer_q        <= '0;
      result_q       <= '0;
      coeff_ready_q  <= 1'b1;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      timer_q        <= timer_d;
      result_q       <= result_d;
      coeff_ready_q  <= (state_d == StLoad);
      start_q        <= (state_d == StStart);
      result_valid_q <= (state_d == StResult);
      error_q        <= (state_d == StError);
    end
  end

endmodule
